// File: rtl/sd_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_responder
// Description : Card-side model of the SD CMD line. Receives 48-bit host
//               commands, validates CRC7/framing, decodes them for a card
//               data-path model and answers with R1, R3 or R7 responses.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_responder #(
  parameter int unsigned NCR        = 2,
  parameter int unsigned ACMD41_BSY = 2,
  parameter logic [31:0] OCR        = 32'h40FF8000
) (
  input  logic        msoc_clk,
  input  logic        sys_rst,
  input  logic        sd_clk_en,
  input  logic        sd_cmd_i,
  output logic        sd_cmd_o,
  output logic        sd_cmd_oe,
  output logic        cmd_val,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg,
  output logic        cmd_app,
  output logic        crc_err,
  output logic        card_ready
);

  localparam int unsigned   WCW      = $clog2(NCR + 2);
  localparam logic [WCW-1:0] NCR_C   = WCW'(NCR);
  localparam int unsigned   BCW      = $clog2(ACMD41_BSY + 2);
  localparam logic [BCW-1:0] BSY_SAT = BCW'(ACMD41_BSY);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RX    = 3'd1,
    ST_CHECK = 3'd2,
    ST_WAIT  = 3'd3,
    ST_TX    = 3'd4
  } state_t;

  // CRC7, polynomial x^7 + x^3 + 1, zero initial value, over 40 bits MSB first
  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_t         state, state_nxt;
  logic [47:0]    rx_sr, rx_sr_nxt;
  logic [5:0]     rx_cnt, rx_cnt_nxt;
  logic [47:0]    tx_sr, tx_sr_nxt;
  logic [5:0]     tx_cnt, tx_cnt_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic [BCW-1:0] busy_cnt, busy_cnt_nxt;
  logic           app_flag, app_flag_nxt;
  logic           com_crc_flag, com_crc_flag_nxt;
  logic           illegal_flag, illegal_flag_nxt;
  logic           card_ready_nxt;
  logic           sd_cmd_o_nxt, sd_cmd_oe_nxt;
  logic           cmd_val_nxt, crc_err_nxt, cmd_app_nxt;
  logic [5:0]     cmd_idx_nxt;
  logic [31:0]    cmd_arg_nxt;

  // decode of the received frame
  logic [5:0]  rx_idx;
  logic [31:0] rx_arg;
  logic        frame_ok;
  logic        acmd_idx;
  logic        is_acmd;
  logic        std_legal;
  logic        is_cmd55;
  logic        busy_ready;
  logic [31:0] r1_status;
  logic [39:0] r1_body;
  logic [39:0] r7_body;
  logic [47:0] r1_frame;
  logic [47:0] r7_frame;
  logic [47:0] r3_frame;

  // Frame validation, command classification and response assembly
  always_comb begin
    rx_idx   = rx_sr[45:40];
    rx_arg   = rx_sr[39:8];
    frame_ok = rx_sr[46] && rx_sr[0] && (crc7_40(rx_sr[47:8]) == rx_sr[7:1]);

    case (rx_idx)
      6'd6, 6'd41, 6'd51: acmd_idx = 1'b1;
      default:            acmd_idx = 1'b0;
    endcase
    // After CMD55, only defined application indices are decoded as ACMDs;
    // anything else falls back to the standard command set.
    is_acmd = app_flag && acmd_idx;

    case (rx_idx)
      6'd0, 6'd2, 6'd3, 6'd7, 6'd8, 6'd9, 6'd12, 6'd13,
      6'd16, 6'd17, 6'd18, 6'd24, 6'd25, 6'd55: std_legal = 1'b1;
      default:                                   std_legal = 1'b0;
    endcase

    is_cmd55   = !is_acmd && (rx_idx == 6'd55);
    busy_ready = (busy_cnt >= BSY_SAT);

    r1_status       = 32'd0;
    r1_status[23]   = com_crc_flag;
    r1_status[22]   = illegal_flag;
    r1_status[12:9] = card_ready ? 4'd4 : 4'd0;
    r1_status[8]    = card_ready;
    r1_status[5]    = is_cmd55;

    r1_body  = {2'b00, rx_idx, r1_status};
    r1_frame = {r1_body, crc7_40(r1_body), 1'b1};
    r7_body  = {2'b00, 6'd8, 20'h0, rx_arg[11:0]};
    r7_frame = {r7_body, crc7_40(r7_body), 1'b1};
    r3_frame = {2'b00, 6'h3F, busy_ready, OCR[30:0], 7'h7F, 1'b1};
  end

  // Next-state and output logic; every register holds unless its state acts
  always_comb begin
    state_nxt        = state;
    rx_sr_nxt        = rx_sr;
    rx_cnt_nxt       = rx_cnt;
    tx_sr_nxt        = tx_sr;
    tx_cnt_nxt       = tx_cnt;
    wait_cnt_nxt     = wait_cnt;
    busy_cnt_nxt     = busy_cnt;
    app_flag_nxt     = app_flag;
    com_crc_flag_nxt = com_crc_flag;
    illegal_flag_nxt = illegal_flag;
    card_ready_nxt   = card_ready;
    sd_cmd_o_nxt     = sd_cmd_o;
    sd_cmd_oe_nxt    = sd_cmd_oe;
    cmd_idx_nxt      = cmd_idx;
    cmd_arg_nxt      = cmd_arg;
    cmd_app_nxt      = cmd_app;
    cmd_val_nxt      = 1'b0;
    crc_err_nxt      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (sd_clk_en && !sd_cmd_i) begin
          rx_sr_nxt  = {rx_sr[46:0], sd_cmd_i};
          rx_cnt_nxt = 6'd1;
          state_nxt  = ST_RX;
        end
      end

      ST_RX: begin
        if (sd_clk_en) begin
          rx_sr_nxt  = {rx_sr[46:0], sd_cmd_i};
          rx_cnt_nxt = rx_cnt + 6'd1;
          if (rx_cnt == 6'd47) state_nxt = ST_CHECK;
        end
      end

      ST_CHECK: begin
        state_nxt = ST_IDLE;
        // a strobe landing on this cycle already counts as the first gap bit
        wait_cnt_nxt = sd_clk_en ? WCW'(1) : '0;
        if (!frame_ok) begin
          crc_err_nxt      = 1'b1;
          com_crc_flag_nxt = 1'b1;
        end else begin
          cmd_val_nxt  = 1'b1;
          cmd_idx_nxt  = rx_idx;
          cmd_arg_nxt  = rx_arg;
          cmd_app_nxt  = is_acmd;
          app_flag_nxt = is_cmd55;
          if (!is_acmd && (rx_idx == 6'd0)) begin
            card_ready_nxt   = 1'b0;
            busy_cnt_nxt     = '0;
            com_crc_flag_nxt = 1'b0;
            illegal_flag_nxt = 1'b0;
            app_flag_nxt     = 1'b0;
          end else if (!is_acmd && !std_legal) begin
            illegal_flag_nxt = 1'b1;
          end else if (is_acmd && (rx_idx == 6'd41)) begin
            tx_sr_nxt = r3_frame;
            if (!busy_ready) busy_cnt_nxt = busy_cnt + 1'b1;
            if (busy_ready) card_ready_nxt = 1'b1;
            state_nxt = ST_WAIT;
          end else if (!is_acmd && (rx_idx == 6'd8)) begin
            tx_sr_nxt = r7_frame;
            state_nxt = ST_WAIT;
          end else begin
            // status flags are cleared once they have been reported
            tx_sr_nxt        = r1_frame;
            com_crc_flag_nxt = 1'b0;
            illegal_flag_nxt = 1'b0;
            state_nxt        = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (sd_clk_en) begin
          if (wait_cnt == NCR_C) begin
            sd_cmd_o_nxt  = tx_sr[47];
            sd_cmd_oe_nxt = 1'b1;
            tx_sr_nxt     = {tx_sr[46:0], 1'b1};
            tx_cnt_nxt    = 6'd1;
            state_nxt     = ST_TX;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
      end

      ST_TX: begin
        if (sd_clk_en) begin
          if (tx_cnt == 6'd48) begin
            sd_cmd_o_nxt  = 1'b1;
            sd_cmd_oe_nxt = 1'b0;
            state_nxt     = ST_IDLE;
          end else begin
            sd_cmd_o_nxt = tx_sr[47];
            tx_sr_nxt    = {tx_sr[46:0], 1'b1};
            tx_cnt_nxt   = tx_cnt + 6'd1;
          end
        end
      end

      default: begin
        state_nxt     = ST_IDLE;
        sd_cmd_o_nxt  = 1'b1;
        sd_cmd_oe_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge msoc_clk) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      rx_sr        <= '0;
      rx_cnt       <= '0;
      tx_sr        <= '1;
      tx_cnt       <= '0;
      wait_cnt     <= '0;
      busy_cnt     <= '0;
      app_flag     <= 1'b0;
      com_crc_flag <= 1'b0;
      illegal_flag <= 1'b0;
      card_ready   <= 1'b0;
      sd_cmd_o     <= 1'b1;
      sd_cmd_oe    <= 1'b0;
      cmd_val      <= 1'b0;
      cmd_idx      <= '0;
      cmd_arg      <= '0;
      cmd_app      <= 1'b0;
      crc_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      rx_sr        <= rx_sr_nxt;
      rx_cnt       <= rx_cnt_nxt;
      tx_sr        <= tx_sr_nxt;
      tx_cnt       <= tx_cnt_nxt;
      wait_cnt     <= wait_cnt_nxt;
      busy_cnt     <= busy_cnt_nxt;
      app_flag     <= app_flag_nxt;
      com_crc_flag <= com_crc_flag_nxt;
      illegal_flag <= illegal_flag_nxt;
      card_ready   <= card_ready_nxt;
      sd_cmd_o     <= sd_cmd_o_nxt;
      sd_cmd_oe    <= sd_cmd_oe_nxt;
      cmd_val      <= cmd_val_nxt;
      cmd_idx      <= cmd_idx_nxt;
      cmd_arg      <= cmd_arg_nxt;
      cmd_app      <= cmd_app_nxt;
      crc_err      <= crc_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_cmd_responder
// Description : Directed self-checking bench for sd_cmd_responder. Acts as
//               the SD host: serialises commands and deserialises responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_responder;

  localparam int NCR = 2;

  logic        msoc_clk  = 1'b0;
  logic        sys_rst   = 1'b1;
  logic        sd_clk_en = 1'b0;
  logic        sd_cmd_i  = 1'b1;
  logic        sd_cmd_o;
  logic        sd_cmd_oe;
  logic        cmd_val;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        cmd_app;
  logic        crc_err;
  logic        card_ready;

  int checks   = 0;
  int failures = 0;
  int val_cnt  = 0;
  int err_cnt  = 0;

  sd_cmd_responder #(.NCR(NCR), .ACMD41_BSY(2), .OCR(32'h40FF8000)) dut (
    .msoc_clk   (msoc_clk),
    .sys_rst    (sys_rst),
    .sd_clk_en  (sd_clk_en),
    .sd_cmd_i   (sd_cmd_i),
    .sd_cmd_o   (sd_cmd_o),
    .sd_cmd_oe  (sd_cmd_oe),
    .cmd_val    (cmd_val),
    .cmd_idx    (cmd_idx),
    .cmd_arg    (cmd_arg),
    .cmd_app    (cmd_app),
    .crc_err    (crc_err),
    .card_ready (card_ready)
  );

  always #5 msoc_clk = ~msoc_clk;

  // one SD bit-time strobe every four system clocks
  initial begin
    forever begin
      repeat (3) @(negedge msoc_clk);
      sd_clk_en = 1'b1;
      @(negedge msoc_clk);
      sd_clk_en = 1'b0;
    end
  end

  // pulse counters for cmd_val / crc_err
  always @(posedge msoc_clk) begin
    if (cmd_val) val_cnt <= val_cnt + 1;
    if (crc_err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // CRC7 as remainder of (data * x^7) mod (x^7 + x^3 + 1)
  function automatic logic [6:0] bcrc(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [39:0] b);
    return {b, bcrc(b), 1'b1};
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    return mk_frame({2'b01, idx, arg});
  endfunction

  function automatic logic [47:0] mk_r1(input logic [5:0] idx, input logic [31:0] st);
    return mk_frame({2'b00, idx, st});
  endfunction

  function automatic logic [47:0] mk_r3(input logic [31:0] ocr);
    return {2'b00, 6'h3F, ocr, 7'h7F, 1'b1};
  endfunction

  task automatic wait_strobe();
    do @(posedge msoc_clk); while (sd_clk_en !== 1'b1);
    #1;
  endtask

  task automatic send_cmd(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      sd_cmd_i = f[i];
      wait_strobe();
    end
    sd_cmd_i = 1'b1;
  endtask

  // gap = idle bit-times after the command end bit before the start bit
  task automatic receive(input int limit, output logic [47:0] r, output int gap, output bit got);
    r   = '1;
    gap = 0;
    got = 1'b0;
    for (int n = 0; n < limit; n++) begin
      wait_strobe();
      if (sd_cmd_oe) begin
        got = 1'b1;
        break;
      end
      gap++;
    end
    if (got) begin
      r[47] = sd_cmd_o;
      for (int i = 46; i >= 0; i--) begin
        wait_strobe();
        r[i] = sd_cmd_o;
      end
      wait_strobe();
    end
  endtask

  task automatic xfer(input string tag, input logic [47:0] f, input logic [47:0] exp);
    logic [47:0] r;
    int          gap;
    bit          got;
    send_cmd(f);
    receive(20, r, gap, got);
    check({tag, "_seen"}, 64'(got), 64'd1);
    check({tag, "_resp"}, 64'(r), 64'(exp));
  endtask

  logic [47:0] r;
  int          gap;
  bit          got;
  int          v0, e0;

  initial begin
    repeat (4) @(posedge msoc_clk);
    #1;
    check("rst_o", 64'(sd_cmd_o), 64'd1);
    check("rst_oe", 64'(sd_cmd_oe), 64'd0);
    check("rst_val", 64'(cmd_val), 64'd0);
    check("rst_idx", 64'(cmd_idx), 64'd0);
    check("rst_arg", 64'(cmd_arg), 64'd0);
    check("rst_app", 64'(cmd_app), 64'd0);
    check("rst_crcerr", 64'(crc_err), 64'd0);
    check("rst_ready", 64'(card_ready), 64'd0);
    @(negedge msoc_clk);
    sys_rst = 1'b0;
    repeat (2) wait_strobe();

    // 1: CMD0 decodes, never answers
    v0 = val_cnt;
    send_cmd(48'h40_0000_0000_95);
    receive(100, r, gap, got);
    check("t1_val", 64'(val_cnt - v0), 64'd1);
    check("t1_idx", 64'(cmd_idx), 64'd0);
    check("t1_no_oe", 64'(got), 64'd0);

    // 2: CMD8 -> R7 after exactly NCR idle bit-times
    send_cmd(48'h48_0000_01AA_87);
    receive(20, r, gap, got);
    check("t2_seen", 64'(got), 64'd1);
    check("t2_gap", 64'(gap), 64'(NCR));
    check("t2_resp", 64'(r), 64'h08_0000_01AA_13);
    check("t2_idx", 64'(cmd_idx), 64'd8);
    check("t2_arg", 64'(cmd_arg), 64'h1AA);
    check("t2_oe_after", 64'(sd_cmd_oe), 64'd0);
    check("t2_o_after", 64'(sd_cmd_o), 64'd1);

    // 3: bad CRC -> crc_err, silence; COM_CRC reported once
    v0 = val_cnt;
    e0 = err_cnt;
    send_cmd(48'h48_0000_01AA_86);
    receive(60, r, gap, got);
    check("t3_err", 64'(err_cnt - e0), 64'd1);
    check("t3_val", 64'(val_cnt - v0), 64'd0);
    check("t3_no_oe", 64'(got), 64'd0);
    xfer("t3_cmd55", mk_cmd(6'd55, 32'd0), mk_r1(6'd55, 32'h0080_0020));
    xfer("t3_cmd13", mk_cmd(6'd13, 32'd0), mk_r1(6'd13, 32'h0000_0000));

    // 4: ACMD41 busy twice, then ready
    for (int k = 0; k < 3; k++) begin
      xfer("t4_cmd55", mk_cmd(6'd55, 32'd0), mk_r1(6'd55, 32'h0000_0020));
      xfer("t4_acmd41", mk_cmd(6'd41, 32'h40FF8000),
           mk_r3((k < 2) ? 32'h40FF8000 : 32'hC0FF8000));
      check("t4_app", 64'(cmd_app), 64'd1);
      check("t4_ready", 64'(card_ready), (k == 2) ? 64'd1 : 64'd0);
    end

    // 6: CMD17 after CMD55 is a standard command
    xfer("t6_cmd55", mk_cmd(6'd55, 32'd0), mk_r1(6'd55, 32'h0000_0920));
    xfer("t6_cmd17", mk_cmd(6'd17, 32'd0), mk_r1(6'd17, 32'h0000_0900));
    check("t6_app", 64'(cmd_app), 64'd0);
    check("t6_idx", 64'(cmd_idx), 64'd17);

    // illegal CMD5: no response, flagged in the next R1
    v0 = val_cnt;
    send_cmd(mk_cmd(6'd5, 32'd0));
    receive(60, r, gap, got);
    check("ill_no_oe", 64'(got), 64'd0);
    check("ill_val", 64'(val_cnt - v0), 64'd1);
    xfer("ill_cmd13", mk_cmd(6'd13, 32'd0), mk_r1(6'd13, 32'h0040_0900));

    // 5: reset in the middle of a response
    send_cmd(48'h48_0000_01AA_87);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      wait_strobe();
      if (sd_cmd_oe) begin
        got = 1'b1;
        break;
      end
    end
    check("t5_tx_start", 64'(got), 64'd1);
    repeat (10) wait_strobe();
    check("t5_mid_oe", 64'(sd_cmd_oe), 64'd1);
    @(negedge msoc_clk);
    sys_rst = 1'b1;
    @(posedge msoc_clk);
    #1;
    check("t5_rst_oe", 64'(sd_cmd_oe), 64'd0);
    check("t5_rst_o", 64'(sd_cmd_o), 64'd1);
    check("t5_rst_ready", 64'(card_ready), 64'd0);
    @(negedge msoc_clk);
    sys_rst = 1'b0;
    repeat (3) wait_strobe();
    xfer("t5_cmd8", 48'h48_0000_01AA_87, 48'h08_0000_01AA_13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
